// File: rtl/mux_2to1_stream.sv
// Two-source stream merger with a one-entry registered output stage and round-robin arbitration.
// Define MUX2_PKT_LOCK_EN to hold the grant on one source until that packet's last beat.
module mux_2to1_stream #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  input  logic              a_last,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  input  logic              b_last,
  output logic              b_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_sel,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              out_sel_q, out_sel_d;

  logic              load_en;
  logic              grant_a, grant_b;
  logic              acc_a, acc_b;

  // last_grant_q: 0 = A, 1 = B; on a tie the source that did not win last time is served
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: begin
        if (a_valid && (!b_valid || last_grant_q)) grant_a = 1'b1;
        else if (b_valid)                          grant_b = 1'b1;
      end
    endcase
  end

  // Readies are gated by rst_n so nothing is accepted while reset is held
  assign load_en = !out_valid_q || out_ready;
  assign a_ready = rst_n && load_en && grant_a;
  assign b_ready = rst_n && load_en && grant_b;
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_sel_d    = out_sel_q;

    if (load_en) out_valid_d = acc_a || acc_b;

    if (acc_a) begin
      out_data_d   = a_data;
      out_last_d   = a_last;
      out_sel_d    = 1'b0;
      last_grant_d = 1'b0;
    end else if (acc_b) begin
      out_data_d   = b_data;
      out_last_d   = b_last;
      out_sel_d    = 1'b1;
      last_grant_d = 1'b1;
    end

`ifdef MUX2_PKT_LOCK_EN
    unique case (state_q)
      LOCK_A:  if (acc_a && a_last) state_d = IDLE;
      LOCK_B:  if (acc_b && b_last) state_d = IDLE;
      default: begin
        if (acc_a && !a_last)      state_d = LOCK_A;
        else if (acc_b && !b_last) state_d = LOCK_B;
      end
    endcase
`else
    state_d = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_sel_q    <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/mux_2to1_stream.md
MUX_2TO1_STREAM -- requirements
Module: mux_2to1_stream

Interface
REQ-001 Parameter: DATA_W, default 8, width of every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: a_data  input  DATA_W  source A beat payload.
REQ-005 Port: a_valid  input  1  source A beat present.
REQ-006 Port: a_last  input  1  source A beat ends a packet.
REQ-007 Port: a_ready  output  1  source A beat accepted when a_valid and a_ready both high.
REQ-008 Port: b_data, b_valid, b_last  input  DATA_W/1/1  source B, same meaning as A.
REQ-009 Port: b_ready  output  1  source B accept, same rule as A.
REQ-010 Port: out_data  output  DATA_W  registered merged payload.
REQ-011 Port: out_valid  output  1  output register holds a beat.
REQ-012 Port: out_last  output  1  registered copy of accepted beat's last flag.
REQ-013 Port: out_sel  output  1  source of held beat: 0 = A, 1 = B.
REQ-014 Port: out_ready  input  1  sink accepts beat when out_valid and out_ready both high.

Function
REQ-015 One-entry output register; load_en = !out_valid || out_ready.
REQ-016 a_ready SHALL be load_en and grant==A; b_ready SHALL be load_en and grant==B; both never high together.
REQ-017 Accepted beat appears on out_data/out_last/out_sel with out_valid high on the next cycle (1-cycle latency).
REQ-018 Full throughput: with out_ready held high, one beat per cycle, no bubbles between back-to-back beats.
REQ-019 out_valid, out_data, out_last, out_sel SHALL hold stable while out_valid high and out_ready low.
REQ-020 When out_ready is high and no input beat is accepted, out_valid SHALL clear on the next cycle.
REQ-021 FSM states: IDLE, LOCK_A, LOCK_B.
REQ-022 IDLE grant: only A valid -> A; only B valid -> B; both valid -> source not in last_grant register (round-robin); neither -> none.
REQ-023 last_grant register updates to the source of every accepted beat.
REQ-024 IDLE -> LOCK_A on accepted A beat with a_last=0; IDLE -> LOCK_B likewise for B; last=1 beat stays in IDLE.
REQ-025 LOCK_x: grant fixed to x regardless of the other source's valid; the other source's ready held low.
REQ-026 LOCK_x -> IDLE on accepted x beat with last=1; otherwise remain.
REQ-027 No beat SHALL be dropped, duplicated or reordered within a source.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, last_grant=B (A wins first tie).
REQ-029 Reset asserted mid-packet SHALL discard the held beat and the lock; no beat accepted while rst_n low (a_ready=b_ready=0).

Configuration
REQ-030 Macro MUX2_PKT_LOCK_EN defined: packet lock per REQ-024..REQ-026 compiled in.
REQ-031 Macro MUX2_PKT_LOCK_EN undefined: FSM stays IDLE; every beat arbitrated per REQ-022; last flags pass through to out_last without affecting grant.

Verification
REQ-032 Reset, then A sends 0x11 (last=1), out_ready=1 -> next cycle out_valid=1, out_data=0x11, out_sel=0, out_last=1.
REQ-033 A and B both valid continuously with single-beat packets (A=0xA0.., B=0xB0..), out_ready=1 -> out_sel alternates 0,1,0,1 starting with A, one beat per cycle.
REQ-034 Lock enabled: A packet 0x01,0x02,0x03(last) with B valid throughout -> out stream 0x01,0x02,0x03 all sel=0, then B beat; b_ready low during A packet.
REQ-035 Beat 0x55 held, out_ready=0 for 5 cycles -> out_data=0x55, out_valid=1 stable, a_ready=b_ready=0; out_ready=1 -> next beat loaded same cycle.
REQ-036 rst_n pulsed low while in LOCK_B -> outputs zero immediately; after release, simultaneous A/B valid grants A first.
REQ-037 Lock disabled build, same stimulus as REQ-034 -> out_sel alternates per beat, out_last passes through unchanged.
